// File: rtl/grid_pos_stepper.sv
// grid_pos_stepper: player position register for the 80x50 play matrix.
// Steps one cell per TICK_DIV clocks while running, steering from debounced
// direction buttons, with start/pause control and border handling.
// Build option: define GRID_POS_WRAP_EN for toroidal wrap at the border;
// left undefined, a move off the grid is blocked and stops the game.
module grid_pos_stepper #(
  parameter int GRID_W   = 80,
  parameter int GRID_H   = 50,
  parameter int TICK_DIV = 25_000_000,
  parameter int START_X  = 40,
  parameter int START_Y  = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       start,
  input  logic       pause,
  output logic [6:0] matrix_idx_x,
  output logic [5:0] matrix_idx_y,
  output logic [1:0] dir,
  output logic [1:0] run_state,
  output logic       pos_valid,
  output logic       edge_hit
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  localparam int              CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [6:0]      X_MAX    = 7'(GRID_W - 1);
  localparam logic [5:0]      Y_MAX    = 6'(GRID_H - 1);
  localparam logic [6:0]      X_START  = 7'(START_X);
  localparam logic [5:0]      Y_START  = 6'(START_Y);

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  dir_e             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       x_q, x_d;
  logic [5:0]       y_q, y_d;
  logic             pos_valid_q, pos_valid_d;
  logic             edge_hit_q, edge_hit_d;

  // Candidate cell for a step in the pending heading, and whether it is blocked.
  logic [6:0] step_x;
  logic [5:0] step_y;
  logic       step_blocked;

  // Compute the target cell; bounds are compared before any increment/decrement.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    step_x       = x_q;
    step_y       = y_q;
    step_blocked = 1'b0;
    unique case (pend_q)
      DIR_RIGHT: begin
        if (x_q == X_MAX) begin
`ifdef GRID_POS_WRAP_EN
          step_x = 7'd0;
`else
          step_blocked = 1'b1;
`endif
        end else begin
          step_x = x_q + 7'd1;
        end
      end
      DIR_LEFT: begin
        if (x_q == 7'd0) begin
`ifdef GRID_POS_WRAP_EN
          step_x = X_MAX;
`else
          step_blocked = 1'b1;
`endif
        end else begin
          step_x = x_q - 7'd1;
        end
      end
      DIR_UP: begin
        if (y_q == 6'd0) begin
`ifdef GRID_POS_WRAP_EN
          step_y = Y_MAX;
`else
          step_blocked = 1'b1;
`endif
        end else begin
          step_y = y_q - 6'd1;
        end
      end
      DIR_DOWN: begin
        if (y_q == Y_MAX) begin
`ifdef GRID_POS_WRAP_EN
          step_y = 6'd0;
`else
          step_blocked = 1'b1;
`endif
        end else begin
          step_y = y_q + 6'd1;
        end
      end
      default: ;
    endcase
  end

  // Next-state: heading sampling, run control, tick counter and stepping.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    pos_valid_d = 1'b0;
    edge_hit_d  = 1'b0;

    // Highest-priority held button that is not a reversal of the committed heading.
    if (btn_up && dir_q != DIR_DOWN)         pend_d = DIR_UP;
    else if (btn_down && dir_q != DIR_UP)    pend_d = DIR_DOWN;
    else if (btn_left && dir_q != DIR_RIGHT) pend_d = DIR_LEFT;
    else if (btn_right && dir_q != DIR_LEFT) pend_d = DIR_RIGHT;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          x_d     = X_START;
          y_d     = Y_START;
          cnt_d   = '0;
          dir_d   = DIR_RIGHT;
          pend_d  = DIR_RIGHT;
        end
      end
      ST_RUN: begin
        if (pause) begin
          // Pause wins over a coincident step; counter holds.
          state_d = ST_PAUSED;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          dir_d = pend_q;
          if (step_blocked) begin
            edge_hit_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            x_d         = step_x;
            y_d         = step_y;
            pos_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PAUSED: begin
        if (pause) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset to the start position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_RIGHT;
      pend_q      <= DIR_RIGHT;
      cnt_q       <= '0;
      x_q         <= X_START;
      y_q         <= Y_START;
      pos_valid_q <= 1'b0;
      edge_hit_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pos_valid_q <= pos_valid_d;
      edge_hit_q  <= edge_hit_d;
    end
  end

  assign matrix_idx_x = x_q;
  assign matrix_idx_y = y_q;
  assign dir          = dir_q;
  assign run_state    = state_q;
  assign pos_valid    = pos_valid_q;
`ifdef GRID_POS_WRAP_EN
  assign edge_hit     = 1'b0;
`else
  assign edge_hit     = edge_hit_q;
`endif

endmodule

// File: tb/tb_grid_pos_stepper.sv
// Scoreboard bench for grid_pos_stepper with TICK_DIV = 4.
// Stimulus pushes expected step results; a negedge monitor pops and compares
// whenever pos_valid or edge_hit is seen. Covers wrap mode when
// GRID_POS_WRAP_EN is defined, blocked mode otherwise.
module tb_grid_pos_stepper;

  localparam logic [1:0] K_PV = 2'b01;  // {edge_hit, pos_valid}
  localparam logic [1:0] K_EH = 2'b10;
  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSED = 2'b10;
  localparam logic [1:0] D_R = 2'b00, D_UP = 2'b10, D_DN = 2'b11;

  logic       clk, rst_n;
  logic       btn_up, btn_down, btn_left, btn_right, start, pause;
  logic [6:0] matrix_idx_x;
  logic [5:0] matrix_idx_y;
  logic [1:0] dir, run_state;
  logic       pos_valid, edge_hit;

  typedef struct {
    logic [1:0] kind;
    logic [6:0] x;
    logic [5:0] y;
    logic [1:0] d;
    logic [1:0] rs;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  grid_pos_stepper #(
    .GRID_W(80), .GRID_H(50), .TICK_DIV(4), .START_X(40), .START_Y(25)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .start(start), .pause(pause),
    .matrix_idx_x(matrix_idx_x), .matrix_idx_y(matrix_idx_y),
    .dir(dir), .run_state(run_state),
    .pos_valid(pos_valid), .edge_hit(edge_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected result, then let exactly one tick period elapse.
  task automatic run_step(input logic [1:0] k, input int x, input int y,
                          input logic [1:0] d, input logic [1:0] rs);
    exp_t e;
    e.kind = k; e.x = 7'(x); e.y = 6'(y); e.d = d; e.rs = rs;
    exp_q.push_back(e);
    repeat (4) tick();
    check("step_timing", 32'({edge_hit, pos_valid}), 32'(k));
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (pos_valid || edge_hit)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got pv=%0b eh=%0b x=%0d y=%0d expected no pulse",
                 pos_valid, edge_hit, matrix_idx_x, matrix_idx_y);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_kind", 32'({edge_hit, pos_valid}), 32'(mon_e.kind));
        check("sb_x", 32'(matrix_idx_x), 32'(mon_e.x));
        check("sb_y", 32'(matrix_idx_y), 32'(mon_e.y));
        check("sb_dir", 32'(dir), 32'(mon_e.d));
        check("sb_state", 32'(run_state), 32'(mon_e.rs));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    {btn_up, btn_down, btn_left, btn_right, start, pause} = '0;
    #12;
    check("rst_x", 32'(matrix_idx_x), 40);
    check("rst_y", 32'(matrix_idx_y), 25);
    check("rst_dir", 32'(dir), 0);
    check("rst_state", 32'(run_state), 0);
    check("rst_pv", 32'(pos_valid), 0);
    check("rst_eh", 32'(edge_hit), 0);
    rst_n = 1'b1;
    tick();

    // Pause is ignored in IDLE.
    pause = 1'b1; tick(); pause = 1'b0;
    check("idle_pause", 32'(run_state), 32'(S_IDLE));

    // Start with no buttons: step right every 4 cycles.
    start = 1'b1; tick(); start = 1'b0;
    check("start_state", 32'(run_state), 32'(S_RUN));
    run_step(K_PV, 41, 25, D_R, S_RUN);
    run_step(K_PV, 42, 25, D_R, S_RUN);

    // Reverse button is ignored; then up turns the heading.
    btn_left = 1'b1;
    run_step(K_PV, 43, 25, D_R, S_RUN);
    btn_left = 1'b0; btn_up = 1'b1;
    run_step(K_PV, 43, 24, D_UP, S_RUN);
    btn_up = 1'b0;

    // Pause coincident with count == 3 suppresses the step.
    repeat (3) tick();
    pause = 1'b1; tick(); pause = 1'b0;
    check("pause_state", 32'(run_state), 32'(S_PAUSED));
    repeat (3) tick();
    check("pause_hold_y", 32'(matrix_idx_y), 24);
    start = 1'b1; tick(); start = 1'b0;
    check("paused_start", 32'(run_state), 32'(S_PAUSED));
    check("paused_start_x", 32'(matrix_idx_x), 43);
    pause = 1'b1; tick(); pause = 1'b0;
    check("resume_state", 32'(run_state), 32'(S_RUN));
    begin
      exp_t e;
      e.kind = K_PV; e.x = 7'd43; e.y = 6'd23; e.d = D_UP; e.rs = S_RUN;
      exp_q.push_back(e);
    end
    tick();
    check("resume_step", 32'(pos_valid), 1);

    // Drive right to the east border.
    btn_right = 1'b1;
    for (int x = 44; x <= 79; x++) run_step(K_PV, x, 23, D_R, S_RUN);
`ifdef GRID_POS_WRAP_EN
    run_step(K_PV, 0, 23, D_R, S_RUN);
    btn_right = 1'b0; btn_up = 1'b1;
    for (int i = 0; i < 24; i++) run_step(K_PV, 0, (i < 23) ? 22 - i : 49, D_UP, S_RUN);
    btn_up = 1'b0;
    check("wrap_y", 32'(matrix_idx_y), 49);
`else
    run_step(K_EH, 79, 23, D_R, S_IDLE);
    btn_right = 1'b0;
    tick();
    check("blocked_idle", 32'(run_state), 32'(S_IDLE));
    check("blocked_x", 32'(matrix_idx_x), 79);
    // Restart reloads the start cell; then one step down.
    start = 1'b1; tick(); start = 1'b0;
    check("restart_x", 32'(matrix_idx_x), 40);
    btn_down = 1'b1;
    run_step(K_PV, 40, 26, D_DN, S_RUN);
    btn_down = 1'b0;
`endif

    // Asynchronous reset at count 2 discards the run immediately.
    repeat (2) tick();
    check("sb_drained_pre_rst", 32'(exp_q.size()), 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_x", 32'(matrix_idx_x), 40);
    check("arst_y", 32'(matrix_idx_y), 25);
    check("arst_dir", 32'(dir), 0);
    check("arst_state", 32'(run_state), 32'(S_IDLE));
    #10 rst_n = 1'b1;
    repeat (6) tick();
    check("post_rst_idle", 32'(run_state), 32'(S_IDLE));
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_pos_stepper.md
# grid_pos_stepper

Produces the player's current cell in the 80×50 play matrix and feeds the index-to-display mapper directly: its `matrix_idx_x`/`matrix_idx_y` outputs connect straight to the mapper's matrix index inputs. Holds a position register and a committed heading. Advances one cell per game tick while running, steering from debounced direction buttons. Includes start/pause control and edge handling at the grid border.

## Interface
- `GRID_W`, 80: matrix columns; x range 0..GRID_W-1.
- `GRID_H`, 50: matrix rows; y range 0..GRID_H-1.
- `TICK_DIV`, 25_000_000: clk cycles per step; minimum 2.
- `START_X`, 40: x loaded at reset and on each start.
- `START_Y`, 25: y loaded at reset and on each start.
- `clk` in 1: the only clock. All logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: level inputs, already synchronised and debounced.
- `start` in 1: one-cycle pulse.
- `pause` in 1: one-cycle toggle pulse.
- `matrix_idx_x` out 7: current column; registered.
- `matrix_idx_y` out 6: current row; registered.
- `dir` out 2: committed heading. 00 = right, 01 = left, 10 = up, 11 = down.
- `run_state` out 2: 00 = IDLE, 01 = RUN, 10 = PAUSED.
- `pos_valid` out 1: one-cycle pulse, high in the cycle the new position is first visible.
- `edge_hit` out 1: one-cycle pulse on a blocked move. Constant 0 when wrap is enabled.

## Operation
- **Reset values:** x = START_X, y = START_Y, dir = 00, pending heading = 00, run_state = IDLE, tick counter = 0, pos_valid = 0, edge_hit = 0.
- **IDLE**
  - Position is frozen and the counter is held at 0.
  - `start` → RUN. In the same edge: load START_X/START_Y, clear the counter, set dir and pending heading to 00.
  - `pause` is ignored.
- **RUN**
  - The counter increments every cycle.
  - When count == TICK_DIV-1: a step occurs and the counter returns to 0.
  - `pause` → PAUSED. It takes priority over a coincident step: no move happens and the counter holds.
  - `start` is ignored.
- **PAUSED**
  - The counter and position are held.
  - `pause` → RUN, and counting resumes from the held count.
  - `start` is ignored.
- **Pending heading**
  - Sampled every cycle in every state. Button priority: up > down > left > right.
  - A button equal to the reverse of the committed dir is ignored; the next-priority button is then considered.
  - With no buttons held, the pending heading is unchanged.
- **Step sequence**
  1. dir ← pending heading.
  2. Move one cell in that new dir.
  3. pos_valid = 1 for one cycle.
- **Arithmetic**
  - x and y are compared against GRID_W-1 / GRID_H-1 before incrementing. Never compute an out-of-range value, then correct it.
  - Output widths are fixed at 7/6 bits. GRID_W ≤ 128 and GRID_H ≤ 64 are required.

## Timing
- Step latency: pos_valid and the new x/y/dir appear on the edge at which count == TICK_DIV-1 is sampled. That is exactly TICK_DIV cycles after the previous step, or after entry to RUN.
- The first step after `start` comes TICK_DIV cycles after the `start` edge.
- Button-to-heading latency: 1 cycle into the pending register. Commitment waits for the next step.
- pos_valid and edge_hit are mutually exclusive and never high for consecutive cycles (TICK_DIV ≥ 2).
- Asserting rst_n low mid-step discards the step: outputs return to reset values immediately and asynchronously.
- The downstream mapper is combinational, so display coordinates are valid in the same cycle as pos_valid.

## Configuration
- `GRID_POS_WRAP_EN` defined (wrap mode):
  - Moving right from x = GRID_W-1 → x = 0; moving left from x = 0 → x = GRID_W-1.
  - Moving down from y = GRID_H-1 → y = 0; moving up from y = 0 → y = GRID_H-1.
  - edge_hit is tied to 0.
- `GRID_POS_WRAP_EN` undefined (blocked mode):
  - A step that would leave the grid holds the position.
  - The step pulses edge_hit instead of pos_valid and forces run_state → IDLE. dir is still committed.
  - A later `start` reloads START_X/START_Y.

## Test plan
Bench uses TICK_DIV = 4.
- Reset then `start` with no buttons → after 4 cycles x = 41, y = 25, dir = 00, pos_valid = 1 for one cycle; after 8 cycles x = 42.
- Hold btn_left while dir = 00 → pending heading is unchanged and the next step gives x+1. Then btn_up → the next step gives y-1 and dir = 10.
- Wrap mode: drive right from x = 79 → x = 0 and pos_valid = 1. Drive up from y = 0 → y = 49.
- Blocked mode: step right at x = 79 → x stays 79, edge_hit = 1, pos_valid = 0, run_state = 00.
- `pause` in the same cycle the counter reaches 3 → no move. A second `pause` → the step lands exactly 1 cycle later.
- Assert rst_n low while in RUN at count 2 → x = 40, y = 25, run_state = 00 without waiting for a clk edge. `start` in PAUSED → no state change.
